// File: rtl/result_streamer.sv
// Reads result rows from the result BRAM and streams them out one lane per beat on an AXI4-Stream master.
// Optional macro RESULT_STREAMER_PREFETCH_EN adds a shadow row buffer so that rows follow each other with no bubbles.
module result_streamer #(
    parameter int PE_COUNT       = 8,
    parameter int DATA_WIDTH     = 32,
    parameter int INS_ADDR_WIDTH = 8,
    parameter int RD_LATENCY     = 1
) (
    input  logic                           clk,
    input  logic                           rstn,
    input  logic                           start,
    input  logic [INS_ADDR_WIDTH-1:0]      base_addr,
    input  logic [INS_ADDR_WIDTH:0]        row_count,
    output logic                           busy,
    output logic                           done,
    output logic [INS_ADDR_WIDTH-1:0]      bram_r_r_addr,
    input  logic [PE_COUNT*DATA_WIDTH-1:0] bram_r_r_data,
    output logic [DATA_WIDTH-1:0]          m_axis_tdata,
    output logic                           m_axis_tvalid,
    input  logic                           m_axis_tready,
    output logic                           m_axis_tlast
);

    localparam int LANE_W  = (PE_COUNT > 1) ? $clog2(PE_COUNT) : 1;
    localparam int ROW_W   = INS_ADDR_WIDTH + 1;
    localparam int ROWBITS = PE_COUNT * DATA_WIDTH;
    localparam logic [LANE_W-1:0] LANE_LAST  = LANE_W'(PE_COUNT - 1);
    localparam logic [LANE_W-1:0] LANE_ZERO  = LANE_W'(0);
    localparam logic [ROW_W-1:0]  ROWS_ZERO  = ROW_W'(0);
    localparam logic [ROW_W-1:0]  ROWS_ONE   = ROW_W'(1);
    localparam logic [ROW_W-1:0]  ROWS_TWO   = ROW_W'(2);
    localparam logic [1:0]        FCNT_LAST  = 2'(RD_LATENCY);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        STREAM = 2'd2,
        DONE   = 2'd3
    } state_t;

    function automatic logic [DATA_WIDTH-1:0] lane_sel(input logic [ROWBITS-1:0] row,
                                                       input logic [LANE_W-1:0]  idx);
        logic [DATA_WIDTH-1:0] res;
        res = {DATA_WIDTH{1'b0}};
        for (int i = 0; i < PE_COUNT; i++) begin
            res = (idx == LANE_W'(i)) ? row[i*DATA_WIDTH +: DATA_WIDTH] : res;
        end
        return res;
    endfunction

    state_t                    state_r, state_nx_s;
    logic [INS_ADDR_WIDTH-1:0] addr_r, addr_nx_s;
    logic [ROW_W-1:0]          rows_r, rows_nx_s;
    logic [LANE_W-1:0]         lane_r, lane_nx_s, next_lane_s;
    logic [1:0]                fcnt_r, fcnt_nx_s;
    logic [ROWBITS-1:0]        row_r, row_nx_s;
    logic [DATA_WIDTH-1:0]     tdata_r, tdata_nx_s;
    logic                      tvalid_r, tvalid_nx_s;
    logic                      tlast_r, tlast_nx_s;
    logic                      busy_r, busy_nx_s;
    logic                      done_r, done_nx_s;
    logic                      last_row_s;
`ifdef RESULT_STREAMER_PREFETCH_EN
    logic [ROWBITS-1:0]        shadow_r, shadow_nx_s, next_row_s;
    logic [1:0]                pf_cnt_r, pf_cnt_nx_s;
    logic                      pf_pend_r, pf_pend_nx_s;
    logic                      pf_ready_r, pf_ready_nx_s;
`endif

    assign last_row_s  = (rows_r == ROWS_ONE);
    assign next_lane_s = lane_r + LANE_W'(1);

    // Next-state and next-output decode for the transfer FSM
    always_comb begin
        state_nx_s  = state_r;
        addr_nx_s   = addr_r;
        rows_nx_s   = rows_r;
        lane_nx_s   = lane_r;
        fcnt_nx_s   = fcnt_r;
        row_nx_s    = row_r;
        tdata_nx_s  = tdata_r;
        tvalid_nx_s = tvalid_r;
        tlast_nx_s  = tlast_r;
        busy_nx_s   = busy_r;
        done_nx_s   = 1'b0;
`ifdef RESULT_STREAMER_PREFETCH_EN
        shadow_nx_s   = shadow_r;
        pf_cnt_nx_s   = pf_cnt_r;
        pf_pend_nx_s  = pf_pend_r;
        pf_ready_nx_s = pf_ready_r;
        // The shadow may still be landing on the final-lane edge; take it straight from the BRAM then.
        next_row_s    = pf_ready_r ? shadow_r : bram_r_r_data;
`endif
        case (state_r)
            IDLE: begin
                tvalid_nx_s = 1'b0;
                tlast_nx_s  = 1'b0;
                busy_nx_s   = 1'b0;
                if (start) begin
                    addr_nx_s = base_addr;
                    rows_nx_s = row_count;
                    busy_nx_s = 1'b1;
                    lane_nx_s = LANE_ZERO;
                    fcnt_nx_s = 2'd0;
                    if (row_count == ROWS_ZERO) begin
                        state_nx_s = DONE;
                        done_nx_s  = 1'b1;
                    end else begin
                        state_nx_s = FETCH;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            FETCH: begin
                if (fcnt_r == FCNT_LAST) begin
                    row_nx_s    = bram_r_r_data;
                    tdata_nx_s  = lane_sel(bram_r_r_data, LANE_ZERO);
                    tvalid_nx_s = 1'b1;
                    tlast_nx_s  = last_row_s && (LANE_LAST == LANE_ZERO);
                    lane_nx_s   = LANE_ZERO;
                    state_nx_s  = STREAM;
`ifdef RESULT_STREAMER_PREFETCH_EN
                    if (!last_row_s) begin
                        addr_nx_s     = addr_r + INS_ADDR_WIDTH'(1);
                        pf_pend_nx_s  = 1'b1;
                        pf_ready_nx_s = 1'b0;
                        pf_cnt_nx_s   = 2'd0;
                    end else begin
                        pf_pend_nx_s  = 1'b0;
                        pf_ready_nx_s = 1'b0;
                    end
`endif
                end else begin
                    fcnt_nx_s = fcnt_r + 2'd1;
                end
            end
            STREAM: begin
`ifdef RESULT_STREAMER_PREFETCH_EN
                if (pf_pend_r && !pf_ready_r) begin
                    if (pf_cnt_r == FCNT_LAST) begin
                        shadow_nx_s   = bram_r_r_data;
                        pf_ready_nx_s = 1'b1;
                    end else begin
                        pf_cnt_nx_s = pf_cnt_r + 2'd1;
                    end
                end else begin
                    pf_cnt_nx_s = pf_cnt_r;
                end
`endif
                if (tvalid_r && m_axis_tready) begin
                    if (lane_r == LANE_LAST) begin
                        rows_nx_s = rows_r - ROWS_ONE;
                        lane_nx_s = LANE_ZERO;
                        if (last_row_s) begin
                            state_nx_s  = DONE;
                            tvalid_nx_s = 1'b0;
                            tlast_nx_s  = 1'b0;
                            busy_nx_s   = 1'b0;
                            done_nx_s   = 1'b1;
                        end else begin
`ifdef RESULT_STREAMER_PREFETCH_EN
                            row_nx_s   = next_row_s;
                            tdata_nx_s = lane_sel(next_row_s, LANE_ZERO);
                            tlast_nx_s = (rows_r == ROWS_TWO) && (LANE_LAST == LANE_ZERO);
                            if (rows_r != ROWS_TWO) begin
                                addr_nx_s     = addr_r + INS_ADDR_WIDTH'(1);
                                pf_pend_nx_s  = 1'b1;
                                pf_ready_nx_s = 1'b0;
                                pf_cnt_nx_s   = 2'd0;
                            end else begin
                                pf_pend_nx_s  = 1'b0;
                                pf_ready_nx_s = 1'b0;
                            end
`else
                            addr_nx_s   = addr_r + INS_ADDR_WIDTH'(1);
                            fcnt_nx_s   = 2'd0;
                            tvalid_nx_s = 1'b0;
                            tlast_nx_s  = 1'b0;
                            state_nx_s  = FETCH;
`endif
                        end
                    end else begin
                        lane_nx_s  = next_lane_s;
                        tdata_nx_s = lane_sel(row_r, next_lane_s);
                        tlast_nx_s = last_row_s && (next_lane_s == LANE_LAST);
                    end
                end else begin
                    lane_nx_s = lane_r;
                end
            end
            DONE: begin
                busy_nx_s   = 1'b0;
                tvalid_nx_s = 1'b0;
                tlast_nx_s  = 1'b0;
                state_nx_s  = IDLE;
            end
            default: begin
                busy_nx_s   = 1'b0;
                tvalid_nx_s = 1'b0;
                tlast_nx_s  = 1'b0;
                state_nx_s  = IDLE;
            end
        endcase
    end

    // State and output registers; reset clears the stream immediately
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r  <= IDLE;
            addr_r   <= {INS_ADDR_WIDTH{1'b0}};
            rows_r   <= {ROW_W{1'b0}};
            lane_r   <= LANE_ZERO;
            fcnt_r   <= 2'd0;
            row_r    <= {ROWBITS{1'b0}};
            tdata_r  <= {DATA_WIDTH{1'b0}};
            tvalid_r <= 1'b0;
            tlast_r  <= 1'b0;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
`ifdef RESULT_STREAMER_PREFETCH_EN
            shadow_r   <= {ROWBITS{1'b0}};
            pf_cnt_r   <= 2'd0;
            pf_pend_r  <= 1'b0;
            pf_ready_r <= 1'b0;
`endif
        end else begin
            state_r  <= state_nx_s;
            addr_r   <= addr_nx_s;
            rows_r   <= rows_nx_s;
            lane_r   <= lane_nx_s;
            fcnt_r   <= fcnt_nx_s;
            row_r    <= row_nx_s;
            tdata_r  <= tdata_nx_s;
            tvalid_r <= tvalid_nx_s;
            tlast_r  <= tlast_nx_s;
            busy_r   <= busy_nx_s;
            done_r   <= done_nx_s;
`ifdef RESULT_STREAMER_PREFETCH_EN
            shadow_r   <= shadow_nx_s;
            pf_cnt_r   <= pf_cnt_nx_s;
            pf_pend_r  <= pf_pend_nx_s;
            pf_ready_r <= pf_ready_nx_s;
`endif
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign bram_r_r_addr = addr_r;
    assign m_axis_tdata  = tdata_r;
    assign m_axis_tvalid = tvalid_r;
    assign m_axis_tlast  = tlast_r;

endmodule

// File: tb/tb_result_streamer.sv
// Scoreboard bench for result_streamer: a BRAM model with random rows, expected beats queued at start, monitor compares.
module tb_result_streamer;

    localparam int PE   = 8;
    localparam int DW   = 32;
    localparam int AW   = 8;
    localparam int LAT  = 1;
`ifdef RESULT_STREAMER_PREFETCH_EN
    localparam int EXP_GAP = 0;
`else
    localparam int EXP_GAP = LAT + 1;
`endif

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
        int            lane;
    } beat_t;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              start = 1'b0;
    logic [AW-1:0]     base_addr = '0;
    logic [AW:0]       row_count = '0;
    logic              busy, done;
    logic [AW-1:0]     bram_r_r_addr;
    logic [PE*DW-1:0]  bram_r_r_data;
    logic [DW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready = 1'b1;
    logic              m_axis_tlast;

    logic [PE*DW-1:0]  mem [256];
    logic [PE*DW-1:0]  pipe [LAT];
    beat_t             exp_q[$];
    beat_t             mon_b;
    int                n_cmp = 0;
    int                n_bad = 0;
    int                done_seen = 0;
    int                hs_count = 0;
    bit                rand_ready = 1'b0;
    bit                stall_v = 1'b0, gap_meas = 1'b0, last_hs = 1'b0;
    logic [DW-1:0]     stall_d;
    logic              stall_l;
    int                gap_cnt = 0;

    result_streamer #(.PE_COUNT(PE), .DATA_WIDTH(DW), .INS_ADDR_WIDTH(AW), .RD_LATENCY(LAT)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr), .row_count(row_count),
        .busy(busy), .done(done), .bram_r_r_addr(bram_r_r_addr), .bram_r_r_data(bram_r_r_data),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast)
    );

    always #5 clk = ~clk;

    // Synchronous BRAM read port with LAT cycles of latency
    always @(posedge clk) begin
        pipe[0] <= mem[bram_r_r_addr];
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign bram_r_r_data = pipe[LAT-1];

    // Downstream ready, either always high or a random 50 % pattern
    always @(posedge clk) begin
        #1 m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: beat order/content, stall stability, row gap and done timing
    always @(negedge clk) begin
        if (!rstn) begin
            stall_v  = 1'b0;
            gap_meas = 1'b0;
            last_hs  = 1'b0;
        end else begin
            if (last_hs) begin
                chk("done_after_last", {done, busy}, 2'b10);
                last_hs = 1'b0;
            end
            if (done) done_seen++;
            if (stall_v) chk("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, stall_l, stall_d});
            if (gap_meas && !m_axis_tvalid) gap_cnt++;
            if (m_axis_tvalid) begin
                if (gap_meas) begin
                    chk("row_gap", gap_cnt, EXP_GAP);
                    gap_meas = 1'b0;
                end
                if (m_axis_tready) begin
                    hs_count++;
                    stall_v = 1'b0;
                    if (exp_q.size() == 0) begin
                        chk("unexpected_beat", m_axis_tdata, 64'hDEAD_0000_0000);
                    end else begin
                        mon_b = exp_q.pop_front();
                        chk("beat_data", m_axis_tdata, mon_b.data);
                        chk("beat_last", m_axis_tlast, mon_b.last);
                        if (mon_b.last) begin
                            last_hs = 1'b1;
                        end else if (mon_b.lane == PE - 1) begin
                            gap_meas = 1'b1;
                            gap_cnt  = 0;
                        end
                    end
                end else begin
                    stall_v = 1'b1;
                    stall_d = m_axis_tdata;
                    stall_l = m_axis_tlast;
                end
            end else begin
                stall_v = 1'b0;
            end
        end
    end

    // Reference model: every lane of rows base..base+cnt-1 (mod 256), tlast only on the very last lane
    task automatic push_expected(input logic [AW-1:0] base, input int cnt);
        logic [PE*DW-1:0] row;
        logic [AW-1:0]    a;
        beat_t            b;
        for (int r = 0; r < cnt; r++) begin
            a   = AW'(base + r);
            row = mem[a];
            for (int l = 0; l < PE; l++) begin
                b.data = row[l*DW +: DW];
                b.last = (r == cnt - 1) && (l == PE - 1);
                b.lane = l;
                exp_q.push_back(b);
            end
        end
    endtask

    task automatic issue_start(input logic [AW-1:0] base, input int cnt);
        push_expected(base, cnt);
        @(posedge clk);
        #1;
        start     = 1'b1;
        base_addr = base;
        row_count = (AW+1)'(cnt);
        @(posedge clk);
        #1;
        start     = 1'b0;
        base_addr = AW'($urandom);
        row_count = (AW+1)'($urandom);
        chk("busy_on_start", busy, 1'b1);
        chk("addr_on_start", bram_r_r_addr, base);
    endtask

    task automatic run_xfer(input logic [AW-1:0] base, input int cnt, input bit mid_start);
        int ds0;
        int k;
        ds0 = done_seen;
        issue_start(base, cnt);
        if (cnt == 0) begin
            chk("zero_done", {done, busy, m_axis_tvalid}, 3'b110);
            @(posedge clk);
            #1;
            chk("zero_end", {done, busy, m_axis_tvalid}, 3'b000);
        end else begin
            k = 0;
            while (!m_axis_tvalid && k < 20) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("first_valid_lat", k, LAT + 1);
            if (mid_start) begin
                repeat (6) @(posedge clk);
                #1;
                start     = 1'b1;
                base_addr = 8'h80;
                row_count = 9'd5;
                @(posedge clk);
                #1;
                start = 1'b0;
            end
            k = 0;
            while (!done && k < 5000) begin
                @(posedge clk);
                #1;
                k++;
            end
            chk("done_timeout", (k < 5000), 1'b1);
        end
        repeat (3) @(posedge clk);
        #1;
        chk("done_count", done_seen - ds0, 1);
        chk("all_beats", exp_q.size(), 0);
    endtask

    task automatic run_reset_test();
        int hs0;
        int k;
        hs0 = hs_count;
        issue_start(8'h20, 2);
        k = 0;
        while ((hs_count - hs0) < 5 && k < 200) begin
            @(negedge clk);
            #2;
            k++;
        end
        chk("reset_reach_beat5", hs_count - hs0, 5);
        rstn = 1'b0;
        #1;
        chk("rst_mid_outputs", {m_axis_tvalid, busy, done, m_axis_tlast}, 4'b0000);
        chk("rst_mid_addr", bram_r_r_addr, 8'h00);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        run_xfer(8'h21, 1, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            for (int l = 0; l < PE; l++) mem[i][l*DW +: DW] = $urandom;
        #3;
        chk("rst_busy", busy, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_tvalid", m_axis_tvalid, 1'b0);
        chk("rst_tlast", m_axis_tlast, 1'b0);
        chk("rst_tdata", m_axis_tdata, 32'h0);
        chk("rst_addr", bram_r_r_addr, 8'h00);
        repeat (3) @(negedge clk);
        rstn = 1'b1;

        run_xfer(8'h10, 2, 1'b0);
        run_xfer(8'h55, 0, 1'b0);
        rand_ready = 1'b1;
        run_xfer(8'h40, 3, 1'b0);
        rand_ready = 1'b0;
        run_xfer(8'hFF, 2, 1'b0);
        run_xfer(8'h30, 2, 1'b1);
        rand_ready = 1'b1;
        run_reset_test();
        rand_ready = 1'b0;
        run_xfer(8'h00, 256, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, transfer did not complete");
        $fatal(1, "watchdog");
    end

endmodule
